// File: rtl/ec1_datapath_if.sv
// ec1_datapath_if -- control/data bundle between the EC-1 control unit
// (master) and the EC-1 datapath (slave).
// Optional macro EC1_DP_OVF_EN adds the sticky signed-overflow flag Ovf.
interface ec1_datapath_if #(
  parameter int DW = 8,
  parameter int AW = 5
);

  // Control strobes from the control unit
  logic          IRload;
  logic          PCload;
  logic          JMPmux;
  logic          Meminst;
  logic          MemWr;
  logic          Aload;
  logic          Sub;
  logic          Halt;
  logic [1:0]    Asel;

  // External data for the input instruction
  logic [DW-1:0] Input;

  // Program loader write port
  logic          ProgWr;
  logic [AW-1:0] ProgAddr;
  logic [DW-1:0] ProgData;

  // Status and data back towards the control unit / outside world
  logic [2:0]    IR;
  logic          Aeq0;
  logic          Apos;
  logic [DW-1:0] Output;
  logic [AW-1:0] PC;
`ifdef EC1_DP_OVF_EN
  logic          Ovf;
`endif

  modport master (
    output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt, Asel,
    output Input, ProgWr, ProgAddr, ProgData,
`ifdef EC1_DP_OVF_EN
    input  Ovf,
`endif
    input  IR, Aeq0, Apos, Output, PC
  );

  modport slave (
    input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt, Asel,
    input  Input, ProgWr, ProgAddr, ProgData,
`ifdef EC1_DP_OVF_EN
    output Ovf,
`endif
    output IR, Aeq0, Apos, Output, PC
  );

endinterface

// File: rtl/ec1_datapath.sv
// ec1_datapath -- datapath of the EC-1 accumulator machine.
// Holds the unified program/data memory, the instruction register, the
// program counter and the accumulator A with its adder/subtractor.
// The memory has no reset, so a program loaded through the loader port
// survives a reset of the processor registers.
// AW must not exceed DW-3: the jump/operand address is taken from the low
// AW bits of the instruction register, below the 3-bit opcode.
// Optional macro EC1_DP_OVF_EN adds a sticky signed-overflow flag (bus.Ovf)
// that is set by an ALU load whose result sign is wrong and cleared only by
// reset. Without the macro the flag and its logic are absent.
module ec1_datapath #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  ec1_datapath_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  // Accumulator source selections
  localparam logic [1:0] ASEL_ALU  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_MEM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

  // Architectural registers
  logic [DW-1:0] irReg;
  logic [AW-1:0] pcReg;
  logic [DW-1:0] accA;

  // Memory array and its access signals
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic          memWe;
  logic [AW-1:0] memWrAddr;
  logic [DW-1:0] memWrData;

  // Next-state values
  logic [AW-1:0] pcNext;
  logic [DW-1:0] aluResult;
  logic [DW-1:0] accNext;

  // Update enables, all suppressed while the machine is halted
  logic          irEn;
  logic          pcEn;
  logic          accEn;

  // Memory address: operand/jump field of the instruction, or the PC for fetch
  always_comb begin
    memAddr = pcReg;
    if (bus.Meminst) begin
      memAddr = irReg[AW-1:0];
    end
  end

  // Asynchronous memory read of the currently addressed word
  always_comb begin
    memData = mem[memAddr];
  end

  // Write port arbitration: the loader always wins over a datapath store;
  // a datapath store is dropped while halted; nothing is written while the
  // processor is held in reset so a store caught by reset is discarded.
  always_comb begin
    memWe     = 1'b0;
    memWrAddr = memAddr;
    memWrData = accA;
    if (Reset) begin
      if (bus.ProgWr) begin
        memWe     = 1'b1;
        memWrAddr = bus.ProgAddr;
        memWrData = bus.ProgData;
      end else if (bus.MemWr && !bus.Halt) begin
        memWe     = 1'b1;
      end
    end
  end

  // Synchronous memory write; the array deliberately has no reset
  always_ff @(posedge Clock) begin
    if (memWe) begin
      mem[memWrAddr] <= memWrData;
    end
  end

  // Program counter source: jump target from the instruction or the next
  // sequential address, wrapping naturally at the top of memory
  always_comb begin
    pcNext = pcReg + AW'(1);
    if (bus.JMPmux) begin
      pcNext = irReg[AW-1:0];
    end
  end

  // Adder/subtractor between A and the addressed memory word, wrapping at DW bits
  always_comb begin
    aluResult = accA + memData;
    if (bus.Sub) begin
      aluResult = accA - memData;
    end
  end

  // Accumulator source multiplexer
  always_comb begin
    accNext = '0;
    unique case (bus.Asel)
      ASEL_ALU:  accNext = aluResult;
      ASEL_IN:   accNext = bus.Input;
      ASEL_MEM:  accNext = memData;
      ASEL_ZERO: accNext = '0;
      default:   accNext = '0;
    endcase
  end

  // Register update enables gated by Halt
  always_comb begin
    irEn  = bus.IRload && !bus.Halt;
    pcEn  = bus.PCload && !bus.Halt;
    accEn = bus.Aload  && !bus.Halt;
  end

  // IR, PC and A: cleared immediately by reset, otherwise loaded on their
  // strobes. All three sample the pre-edge memory word and PC, so a combined
  // IRload+PCload fetches from the old PC while the PC advances.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      irReg <= '0;
      pcReg <= '0;
      accA  <= '0;
    end else begin
      if (irEn) begin
        irReg <= memData;
      end
      if (pcEn) begin
        pcReg <= pcNext;
      end
      if (accEn) begin
        accA <= accNext;
      end
    end
  end

`ifdef EC1_DP_OVF_EN
  // Signed overflow of the ALU: operands of equal effective sign (the memory
  // operand inverted for subtraction) producing a result of the other sign
  logic ovfNow;
  logic ovfReg;
  logic opSign;

  // Overflow detection for the current ALU operation
  always_comb begin
    opSign = bus.Sub ? ~memData[DW-1] : memData[DW-1];
    ovfNow = (accA[DW-1] == opSign) && (aluResult[DW-1] != accA[DW-1]);
  end

  // Sticky overflow flag, set only by an ALU load into A, cleared only by reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ovfReg <= 1'b0;
    end else if (accEn && (bus.Asel == ASEL_ALU) && ovfNow) begin
      ovfReg <= 1'b1;
    end
  end

  assign bus.Ovf = ovfReg;
`endif

  // Status and data outputs driven straight from the registers
  assign bus.IR     = irReg[DW-1:DW-3];
  assign bus.PC     = pcReg;
  assign bus.Output = accA;
  assign bus.Aeq0   = (accA == '0);
  assign bus.Apos   = !accA[DW-1] && (accA != '0);

endmodule
